// File: rtl/vga_timing_gen.sv
// Raster timing core: hc/vc counters, visible-region coordinates, line/frame strobes,
// PIPE-delayed syncs and active flag, and a frame-based animation tick divider.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int ANIM_DIV = 1,
  parameter int CW       = 10
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          en,
  input  logic          anim_pause,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          line_start,
  output logic          frame_start,
  output logic          anim_tick,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_VIS_BEG = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_VIS_END = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_VIS_BEG = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_VIS_END = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0]   DIV_LAST  = 16'(ANIM_DIV - 1);

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic hs_raw, vs_raw, act_raw, h_vis, v_vis;
  logic hs_dly, vs_dly, act_dly;
  logic fs_raw, ls_raw, tick_raw;

  // Raster counters: vc only moves on the last pixel of a line.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  always_comb begin
    hs_raw  = (hc_q < H_SYNC_C);
    vs_raw  = (vc_q < V_SYNC_C);
    h_vis   = (hc_q >= H_VIS_BEG) && (hc_q < H_VIS_END);
    v_vis   = (vc_q >= V_VIS_BEG) && (vc_q < V_VIS_END);
    act_raw = h_vis && v_vis;
    px      = act_raw ? (hc_q - H_VIS_BEG) : '0;
    py      = act_raw ? (vc_q - V_VIS_BEG) : '0;
  end

  // Strobes are suppressed while reset is held so nothing downstream sees a stale frame edge.
  always_comb begin
    ls_raw   = en && clr_n && (hc_q == '0);
    fs_raw   = ls_raw && (vc_q == '0);
    tick_raw = fs_raw && !anim_pause && (div_q == DIV_LAST);
  end

  always_comb begin
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q;
    if (fs_raw) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (!anim_pause) begin
        div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      div_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Delay line for {hs, vs, act}; stage 0 takes the raw values, stage PIPE-1 drives the outputs.
  generate
    if (PIPE == 0) begin : g_no_pipe
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
      assign act_dly = act_raw;
    end else begin : g_pipe
      logic [2:0] sr_q [PIPE];
      logic [2:0] sr_d [PIPE];

      always_comb begin
        sr_d = sr_q;
        if (en) begin
          sr_d[0] = {hs_raw, vs_raw, act_raw};
          for (int i = 1; i < PIPE; i++) begin
            sr_d[i] = sr_q[i-1];
          end
        end
      end

      always_ff @(posedge dclk) begin
        if (!clr_n) begin
          for (int i = 0; i < PIPE; i++) begin
            sr_q[i] <= 3'b000;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign hs_dly  = sr_q[PIPE-1][2];
      assign vs_dly  = sr_q[PIPE-1][1];
      assign act_dly = sr_q[PIPE-1][0];
    end
  endgenerate

  // Polarity is applied after the delay so cleared stages read as deasserted syncs.
  assign hsync       = HS_POL ? hs_dly : !hs_dly;
  assign vsync       = VS_POL ? vs_dly : !vs_dly;
  assign active      = act_dly;
  assign line_start  = ls_raw;
  assign frame_start = fs_raw;
  assign anim_tick   = tick_raw;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, compared each cycle against
// an arithmetic model driven by the count of enabled cycles since reset.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b1;
  localparam int PIPE     = 2;
  localparam int ANIM_DIV = 3;
  localparam int CW       = 6;

  localparam int HT    = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 15
  localparam int VT    = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 10
  localparam int FRAME = HT * VT;                          // 150
  localparam int MAX_MIS = 40;

  logic          dclk = 1'b0;
  logic          clr_n, en, anim_pause;
  logic          hsync, vsync, active, line_start, frame_start, anim_tick;
  logic [CW-1:0] px, py;
  logic [15:0]   frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIPE(PIPE), .ANIM_DIV(ANIM_DIV), .CW(CW)
  ) dut (
    .dclk(dclk), .clr_n(clr_n), .en(en), .anim_pause(anim_pause),
    .hsync(hsync), .vsync(vsync), .active(active), .px(px), .py(py),
    .line_start(line_start), .frame_start(frame_start), .anim_tick(anim_tick),
    .frame_cnt(frame_cnt)
  );

  always #5 dclk = ~dclk;

  int n_vec = 0;
  int n_mis = 0;
  int t     = 0;  // enabled cycles since reset
  int unp   = 0;  // unpaused frame starts consumed since reset
  logic obs_hs, obs_vs, obs_fs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time=%0t)", tag, got, exp, t, $time);
    end
  endtask

  function automatic bit hs_at(input int tt);
    return (tt % HT) < H_SYNC;
  endfunction

  function automatic bit vs_at(input int tt);
    return ((tt / HT) % VT) < V_SYNC;
  endfunction

  function automatic bit act_at(input int tt);
    int h, v;
    h = tt % HT;
    v = (tt / HT) % VT;
    return (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
           (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
  endfunction

  task automatic step(input bit e, input bit p, input bit c);
    bit a_h, a_v, a_a, fs, ls, tk;
    int xp, yp;
    @(negedge dclk);
    en = e; anim_pause = p; clr_n = c;
    #1;
    a_h = (t >= PIPE) ? hs_at(t - PIPE)  : 1'b0;
    a_v = (t >= PIPE) ? vs_at(t - PIPE)  : 1'b0;
    a_a = (t >= PIPE) ? act_at(t - PIPE) : 1'b0;
    xp  = act_at(t) ? (t % HT) - (H_SYNC + H_BP) : 0;
    yp  = act_at(t) ? ((t / HT) % VT) - (V_SYNC + V_BP) : 0;
    ls  = c && e && (t % HT == 0);
    fs  = c && e && (t % FRAME == 0);
    tk  = fs && !p && (unp % ANIM_DIV == ANIM_DIV - 1);
    chk("hsync",       32'(hsync),       32'(HS_POL ? a_h : !a_h));
    chk("vsync",       32'(vsync),       32'(VS_POL ? a_v : !a_v));
    chk("active",      32'(active),      32'(a_a));
    chk("px",          32'(px),          32'(xp));
    chk("py",          32'(py),          32'(yp));
    chk("line_start",  32'(line_start),  32'(ls));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("anim_tick",   32'(anim_tick),   32'(tk));
    chk("frame_cnt",   32'(frame_cnt),   32'(((t + FRAME - 1) / FRAME) % 65536));
    obs_hs = hsync; obs_vs = vsync; obs_fs = frame_start;
    @(posedge dclk);
    if (!c) begin
      t = 0; unp = 0;
    end else if (e) begin
      if (fs && !p) unp++;
      t++;
    end
  endtask

  initial begin
    int hs_cnt, vs_cnt, fs_first, fs_second;
    bit pz;
    clr_n = 1'b0; en = 1'b0; anim_pause = 1'b0;
    repeat (3) @(posedge dclk);
    t = 0; unp = 0;

    // Free-running frames: sync duty per frame and first strobe after release.
    step(1'b1, 1'b0, 1'b0);
    hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 0) chk("fs_after_release", 32'(obs_fs), 32'd1);
      if (i >= FRAME) begin
        if (obs_hs == HS_POL) hs_cnt++;
        if (obs_vs == VS_POL) vs_cnt++;
      end
    end
    chk("hs_assert_per_frame", 32'(hs_cnt), 32'(H_SYNC * VT));
    chk("vs_assert_per_frame", 32'(vs_cnt), 32'(V_SYNC * HT));

    // en toggling 1,0: frame period doubles in dclk cycles.
    step(1'b1, 1'b0, 1'b0);
    fs_first = -1; fs_second = -1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step(i % 2 == 0, 1'b0, 1'b1);
      if (obs_fs) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    chk("fs_period_half_en", 32'(fs_second - fs_first), 32'(2 * FRAME));

    // Random enable with pause toggling across whole frames.
    pz = 1'b0;
    for (int i = 0; i < 3000 && n_mis < MAX_MIS; i++) begin
      if ($urandom_range(0, 99) < 3) pz = ~pz;
      step($urandom_range(0, 99) < 70, pz, 1'b1);
    end

    // Random enable/pause plus occasional mid-frame resets, some with en=0.
    for (int i = 0; i < 4000 && n_mis < MAX_MIS; i++) begin
      step($urandom_range(0, 99) < 75, $urandom_range(0, 1) == 1,
           $urandom_range(0, 499) != 0);
    end

    // Long unpaused run so frame_cnt and the divider cover many frames.
    for (int i = 0; i < 1500 && n_mis < MAX_MIS; i++) begin
      step(1'b1, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
